// File: rtl/bram_tile_pkg.sv
// rtl/bram_tile_pkg.sv - Shared FSM encoding and width helper for the BRAM tile reader
package bram_tile_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((64'(1) << result) < 64'(value)) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/tile_out_fifo.sv
// rtl/tile_out_fifo.sv - Synchronous first-word-fall-through FIFO with occupancy count
module tile_out_fifo
    import bram_tile_pkg::*;
#(
    parameter int WIDTH      = 10,
    parameter int DEPTH      = 4,
    localparam int CNT_W     = clog2(DEPTH + 1),
    localparam int PTR_W     = (DEPTH > 1) ? clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_data_o,
    output logic             head_valid_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_pop;

    // The writer only pushes when it holds a credit, so there is no full check here.
    assign do_pop = pop_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push_i) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem[wr_ptr_q] <= push_data_i;
        end
    end

    // Head is forced to zero when empty so no stale entry is ever visible.
    assign head_valid_o = (count_q != '0);
    assign head_data_o  = head_valid_o ? mem[rd_ptr_q] : '0;
    assign count_o      = count_q;

endmodule

// File: rtl/bram_tile_reader.sv
// rtl/bram_tile_reader.sv - Streams a raster-stored frame out of BRAM in tile order
// Optional linear read mode enabled by defining BRAM_TILE_READER_RASTER_EN
module bram_tile_reader
    import bram_tile_pkg::*;
#(
    parameter int RAM_WIDTH   = 8,
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 480,
    parameter int TILE_WIDTH  = 16,
    parameter int TILE_HEIGHT = 16,
    parameter int RAM_DEPTH   = 307200,
    parameter int RD_LAT      = 2,
    parameter int FIFO_DEPTH  = 4,
    localparam int ADDR_W     = clog2(RAM_DEPTH)
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iStart,
`ifdef BRAM_TILE_READER_RASTER_EN
    input  logic                 iRaster,
`endif
    output logic                 oRdEn,
    output logic [ADDR_W-1:0]    oRdAddr,
    input  logic [RAM_WIDTH-1:0] iRdData,
    output logic [RAM_WIDTH-1:0] oData,
    output logic                 oValid,
    input  logic                 iReady,
    output logic                 oTileFirst,
    output logic                 oLast,
    output logic                 oBusy,
    output logic                 oDone
);

    localparam int NUM_TX = IMG_WIDTH / TILE_WIDTH;
    localparam int NUM_TY = IMG_HEIGHT / TILE_HEIGHT;
    localparam int PX_W   = clog2(TILE_WIDTH + 1);
    localparam int PY_W   = clog2(TILE_HEIGHT + 1);
    localparam int TX_W   = clog2(NUM_TX + 1);
    localparam int TY_W   = clog2(NUM_TY + 1);
    localparam int CNT_W  = clog2(FIFO_DEPTH + 1);
    localparam int CRD_W  = clog2(FIFO_DEPTH + RD_LAT + 1) + 1;

    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(IMG_WIDTH - TILE_WIDTH + 1);
    localparam logic [ADDR_W-1:0] TILE_STEP = ADDR_W'(TILE_WIDTH);
    localparam logic [ADDR_W-1:0] BAND_STEP = ADDR_W'(TILE_HEIGHT * IMG_WIDTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);

    state_e              state_q, state_d;
    logic [PX_W-1:0]     px_q, px_d;
    logic [PY_W-1:0]     py_q, py_d;
    logic [TX_W-1:0]     tx_q, tx_d;
    logic [TY_W-1:0]     ty_q, ty_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   tile_base_q, tile_base_d;
    logic [ADDR_W-1:0]   row_base_q, row_base_d;
    logic [RD_LAT-1:0]   vld_q, first_q, last_q;
    logic                done_q, done_d;

    logic                start;
    logic                rd_en;
    logic                raster_mode;
    logic                px_end, py_end, tx_end, ty_end;
    logic                issue_first, issue_last;
    logic                can_issue;
    logic                pop;
    logic [CNT_W-1:0]    fifo_count;
    logic [CRD_W-1:0]    inflight;
    logic [CRD_W-1:0]    credit_used;
    logic [RAM_WIDTH+1:0] head_data;
    logic                head_valid;

    assign start = (state_q == ST_IDLE) && iStart;

`ifdef BRAM_TILE_READER_RASTER_EN
    logic raster_q;

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            raster_q <= 1'b0;
        end else if (start) begin
            raster_q <= iRaster;
        end
    end

    assign raster_mode = raster_q;
`else
    assign raster_mode = 1'b0;
`endif

    assign px_end = (px_q == PX_W'(TILE_WIDTH - 1));
    assign py_end = (py_q == PY_W'(TILE_HEIGHT - 1));
    assign tx_end = (tx_q == TX_W'(NUM_TX - 1));
    assign ty_end = (ty_q == TY_W'(NUM_TY - 1));

    assign issue_first = raster_mode ? (addr_q == '0) : (px_q == '0 && py_q == '0);
    assign issue_last  = raster_mode ? (addr_q == LAST_ADDR) : (px_end && py_end && tx_end && ty_end);

    // Credits: every read in flight or parked in the FIFO holds one slot; a pop this cycle frees one.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CRD_W'(vld_q[i]);
        end
    end

    assign pop         = head_valid && iReady;
    assign credit_used = CRD_W'(fifo_count) + inflight - CRD_W'(pop);
    assign can_issue   = (credit_used < CRD_W'(FIFO_DEPTH));

    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (can_issue) begin
                    rd_en = 1'b1;
                    if (issue_last) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && head_data[0]) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Incremental address walk: tile_base is the current tile origin, row_base the current tile band.
    always_comb begin
        px_d        = px_q;
        py_d        = py_q;
        tx_d        = tx_q;
        ty_d        = ty_q;
        addr_d      = addr_q;
        tile_base_d = tile_base_q;
        row_base_d  = row_base_q;
        if (start) begin
            px_d        = '0;
            py_d        = '0;
            tx_d        = '0;
            ty_d        = '0;
            addr_d      = '0;
            tile_base_d = '0;
            row_base_d  = '0;
        end else if (rd_en) begin
            if (raster_mode) begin
                addr_d = addr_q + ADDR_W'(1);
            end else if (!px_end) begin
                px_d   = px_q + PX_W'(1);
                addr_d = addr_q + ADDR_W'(1);
            end else begin
                px_d = '0;
                if (!py_end) begin
                    py_d   = py_q + PY_W'(1);
                    addr_d = addr_q + ROW_STEP;
                end else begin
                    py_d = '0;
                    if (!tx_end) begin
                        tx_d        = tx_q + TX_W'(1);
                        tile_base_d = tile_base_q + TILE_STEP;
                        addr_d      = tile_base_q + TILE_STEP;
                    end else begin
                        tx_d        = '0;
                        ty_d        = ty_q + TY_W'(1);
                        row_base_d  = row_base_q + BAND_STEP;
                        tile_base_d = row_base_q + BAND_STEP;
                        addr_d      = row_base_q + BAND_STEP;
                    end
                end
            end
        end
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state_q     <= ST_IDLE;
            px_q        <= '0;
            py_q        <= '0;
            tx_q        <= '0;
            ty_q        <= '0;
            addr_q      <= '0;
            tile_base_q <= '0;
            row_base_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            px_q        <= px_d;
            py_q        <= py_d;
            tx_q        <= tx_d;
            ty_q        <= ty_d;
            addr_q      <= addr_d;
            tile_base_q <= tile_base_d;
            row_base_q  <= row_base_d;
            done_q      <= done_d;
        end
    end

    // Flags ride alongside the read so they line up with iRdData RD_LAT cycles later.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            vld_q   <= '0;
            first_q <= '0;
            last_q  <= '0;
        end else begin
            vld_q[0]   <= rd_en;
            first_q[0] <= rd_en && issue_first;
            last_q[0]  <= rd_en && issue_last;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i]   <= vld_q[i-1];
                first_q[i] <= first_q[i-1];
                last_q[i]  <= last_q[i-1];
            end
        end
    end

    tile_out_fifo #(
        .WIDTH (RAM_WIDTH + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i        (iClk),
        .rst_n_i      (iRst),
        .push_i       (vld_q[RD_LAT-1]),
        .push_data_i  ({iRdData, first_q[RD_LAT-1], last_q[RD_LAT-1]}),
        .pop_i        (pop),
        .head_data_o  (head_data),
        .head_valid_o (head_valid),
        .count_o      (fifo_count)
    );

    assign oRdEn      = rd_en;
    assign oRdAddr    = addr_q;
    assign oData      = head_data[RAM_WIDTH+1:2];
    assign oTileFirst = head_data[1];
    assign oLast      = head_data[0];
    assign oValid     = head_valid;
    assign oBusy      = (state_q != ST_IDLE) || done_q;
    assign oDone      = done_q;

endmodule

// File: tb/tb_bram_tile_reader.sv
// tb/tb_bram_tile_reader.sv - Scoreboard bench for bram_tile_reader on a 32x32 frame of 16x16 tiles
module tb_bram_tile_reader;

    localparam int ADDR_W = 10;

    typedef logic [9:0] pix_t;

    logic              iClk = 1'b0;
    logic              iRst;
    logic              iStart;
    logic              oRdEn;
    logic [ADDR_W-1:0] oRdAddr;
    logic [7:0]        iRdData;
    logic [7:0]        oData;
    logic              oValid;
    logic              iReady;
    logic              oTileFirst;
    logic              oLast;
    logic              oBusy;
    logic              oDone;
`ifdef BRAM_TILE_READER_RASTER_EN
    logic              iRaster;
`endif

    logic [7:0] rd_s0, rd_s1;

    pix_t exp_q[$];
    int   n_pass = 0;
    int   n_fail = 0;
    int   n_total = 0;
    int   pix_cnt = 0;
    int   done_cnt = 0;
    int   valid_cycles = 0;
    int   issued = 0;
    int   popped = 0;
    int   max_out = 0;

    always #5 iClk = ~iClk;

    bram_tile_reader #(
        .RAM_WIDTH   (8),
        .IMG_WIDTH   (32),
        .IMG_HEIGHT  (32),
        .TILE_WIDTH  (16),
        .TILE_HEIGHT (16),
        .RAM_DEPTH   (1024),
        .RD_LAT      (2),
        .FIFO_DEPTH  (4)
    ) dut (
        .iClk       (iClk),
        .iRst       (iRst),
        .iStart     (iStart),
`ifdef BRAM_TILE_READER_RASTER_EN
        .iRaster    (iRaster),
`endif
        .oRdEn      (oRdEn),
        .oRdAddr    (oRdAddr),
        .iRdData    (iRdData),
        .oData      (oData),
        .oValid     (oValid),
        .iReady     (iReady),
        .oTileFirst (oTileFirst),
        .oLast      (oLast),
        .oBusy      (oBusy),
        .oDone      (oDone)
    );

    // Two-stage BRAM model holding mem[a] = a[7:0].
    always @(posedge iClk) begin
        if (oRdEn) rd_s0 <= oRdAddr[7:0];
        rd_s1 <= rd_s0;
    end
    assign iRdData = rd_s1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic nsample();
        @(negedge iClk);
        #1;
    endtask

    task automatic start_frame(input bit raster);
        int a;
        if (raster) begin
            for (a = 0; a < 1024; a++) exp_q.push_back({a[7:0], a == 0, a == 1023});
        end else begin
            for (int ty = 0; ty < 2; ty++)
                for (int tx = 0; tx < 2; tx++)
                    for (int py = 0; py < 16; py++)
                        for (int px = 0; px < 16; px++) begin
                            a = (ty * 16 + py) * 32 + tx * 16 + px;
                            exp_q.push_back({a[7:0], px == 0 && py == 0, a == 1023});
                        end
        end
`ifdef BRAM_TILE_READER_RASTER_EN
        iRaster = raster;
`endif
        iStart = 1'b1;
        @(posedge iClk);
        #1;
        iStart = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget; i++) begin
            nsample();
            if (done_cnt != d0) break;
        end
        check(tag, done_cnt - d0, 1);
        check({tag, "_sb_empty"}, exp_q.size(), 0);
        @(posedge iClk);
        #1;
    endtask

    // Monitor: pops the scoreboard on each transfer and tracks stalls and outstanding reads.
    initial begin
        pix_t e;
        logic prev_stall;
        logic [7:0] prev_data;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge iClk);
            if (!iRst) begin
                prev_stall = 1'b0;
                issued = popped;
            end else begin
                if (prev_stall) check("stall_hold", {oValid, oData}, {1'b1, prev_data});
                if (oRdEn) issued++;
                if (oValid && iReady) begin
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                    check($sformatf("pix%0d", pix_cnt), {oData, oTileFirst, oLast}, e);
                    popped++;
                    pix_cnt++;
                end
                if (issued - popped > max_out) max_out = issued - popped;
                prev_stall = oValid && !iReady;
                prev_data  = oData;
                if (oDone) done_cnt++;
                if (oValid) valid_cycles++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, p0, d0, base;
        iRst   = 1'b0;
        iStart = 1'b0;
        iReady = 1'b1;
`ifdef BRAM_TILE_READER_RASTER_EN
        iRaster = 1'b0;
`endif
        repeat (3) @(posedge iClk);
        #1;
        check("reset_outputs", {oRdEn, oRdAddr, oData, oValid, oTileFirst, oLast, oBusy, oDone}, 0);
        iRst = 1'b1;
        @(posedge iClk);
        #1;

        // Tile order with iReady held high, including exact latency.
        v0 = valid_cycles;
        p0 = pix_cnt;
        d0 = done_cnt;
        start_frame(1'b0);
        nsample();
        check("lat_c1_rden_addr", {oRdEn, oRdAddr}, {1'b1, 10'd0});
        check("lat_c1_busy_novalid", {oBusy, oValid}, 2'b10);
        nsample();
        check("lat_c2_novalid", oValid, 0);
        nsample();
        check("lat_c3_novalid", oValid, 0);
        nsample();
        check("lat_c4_valid", oValid, 1);
        repeat (1023) nsample();
        check("stream_c1027", {oValid, oLast, oDone}, 3'b110);
        check("valid_run_1024", valid_cycles - v0, 1024);
        nsample();
        check("done_c1028", {oDone, oValid, oBusy}, 3'b101);
        nsample();
        check("idle_c1029", {oDone, oBusy}, 2'b00);
        check("frame1_pixels", pix_cnt - p0, 1024);
        check("frame1_done", done_cnt - d0, 1);
        check("frame1_sb_empty", exp_q.size(), 0);
        @(posedge iClk);
        #1;

        // Random backpressure, then a long stall that must fill every credit.
        start_frame(1'b0);
        for (int i = 0; i < 300; i++) begin
            iReady = ($urandom_range(0, 1) == 1);
            @(posedge iClk);
            #1;
        end
        iReady = 1'b0;
        repeat (20) nsample();
        check("stall_outstanding_full", issued - popped, 4);
        check("stall_valid_no_issue", {oValid, oRdEn}, 2'b10);
        @(posedge iClk);
        #1;
        iReady = 1'b1;
        wait_done("bp_done", 5000);
        check("credit_bound", (max_out <= 4), 1);

        // Reset in the middle of a frame.
        start_frame(1'b0);
        base = pix_cnt;
        for (int i = 0; i < 2000 && (pix_cnt - base) < 300; i++) @(posedge iClk);
        #1;
        iRst = 1'b0;
        #1;
        check("abort_outputs", {oRdEn, oRdAddr, oData, oValid, oTileFirst, oLast, oBusy, oDone}, 0);
        exp_q.delete();
        d0 = done_cnt;
        repeat (3) @(posedge iClk);
        #1;
        iRst = 1'b1;
        repeat (5) @(posedge iClk);
        #1;
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_idle", {oBusy, oValid}, 2'b00);
        start_frame(1'b0);
        nsample();
        check("restart_addr0", {oRdEn, oRdAddr}, {1'b1, 10'd0});
        wait_done("restart_done", 3000);

        // iStart while busy must be ignored.
        p0 = pix_cnt;
        start_frame(1'b0);
        repeat (50) @(posedge iClk);
        #1;
        iStart = 1'b1;
        @(posedge iClk);
        #1;
        iStart = 1'b0;
        d0 = done_cnt;
        wait_done("restart_ignored_done", 3000);
        repeat (30) nsample();
        check("restart_ignored_pixels", pix_cnt - p0, 1024);
        check("restart_ignored_single_done", done_cnt - d0, 1);
        check("restart_ignored_idle", {oValid, oBusy}, 2'b00);

`ifdef BRAM_TILE_READER_RASTER_EN
        start_frame(1'b1);
        wait_done("raster_done", 3000);
        iRaster = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
